// File: rtl/video_pkg.sv
// Shared definitions for the video pixel feeder: black level, colour-bar table and FSM encoding.
package video_pkg;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;

   typedef enum logic [1:0] {
      ST_WAIT_VS = 2'd0,
      ST_ALIGN   = 2'd1,
      ST_STREAM  = 2'd2
   } feeder_state_e;

   // Eight-bar RGB565 test pattern, left to right.
   function automatic logic [15:0] colour_bar(input logic [2:0] idx);
      logic [15:0] colour_s;
      case (idx)
         3'd0:    colour_s = 16'hFFFF;
         3'd1:    colour_s = 16'hFFE0;
         3'd2:    colour_s = 16'h07FF;
         3'd3:    colour_s = 16'h07E0;
         3'd4:    colour_s = 16'hF81F;
         3'd5:    colour_s = 16'hF800;
         3'd6:    colour_s = 16'h001F;
         3'd7:    colour_s = 16'h0000;
         default: colour_s = RGB565_BLACK;
      endcase
      return colour_s;
   endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock pixel FIFO with a registered read port; the head SOF flag is visible combinationally.
// The read register returns zero on any cycle without a captured read, giving black by default.
module pixel_sync_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 1024,
   parameter int AW         = 10
) (
   input  logic              pixel_clk,
   input  logic              sys_rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_sof,
   input  logic              rd_en,
   input  logic              rd_capture,
   output logic [DATA_W-1:0] rd_data,
   output logic              head_sof,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic              sof_mem_r [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_r;
   logic [AW:0]       rd_ptr_r;
   logic [DATA_W-1:0] rd_data_r;
   logic              full_s;
   logic              empty_s;
   logic              wr_ok_s;
   logic              rd_ok_s;

   // One extra pointer bit separates full from empty when the low bits match.
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign wr_ok_s = wr_en & ~full_s;
   assign rd_ok_s = rd_en & ~empty_s;

   // Storage write; the RAM itself is not reset.
   always_ff @(posedge pixel_clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]]     <= wr_data;
         sof_mem_r[wr_ptr_r[AW-1:0]] <= wr_sof;
      end
   end

   // Read/write pointers.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (wr_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // Registered read data.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_data_r <= {DATA_W{1'b0}};
      end else if (rd_ok_s && rd_capture) begin
         rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
      end else begin
         rd_data_r <= {DATA_W{1'b0}};
      end
   end

   assign rd_data  = rd_data_r;
   assign head_sof = sof_mem_r[rd_ptr_r[AW-1:0]];
   assign full     = full_s;
   assign empty    = empty_s;
   assign level    = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/video_pixel_feeder.sv
// Pixel feeder for the HDMI timing generator: FIFO-buffered stream, frame alignment, black on underflow.
// Optional colour-bar generator enabled by defining VIDEO_TEST_PATTERN_EN.
module video_pixel_feeder
   import video_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 1024,
   parameter int AW         = 10,
   parameter int H_DISP     = 1280,
   parameter int V_DISP     = 720
) (
   input  logic              pixel_clk,
   input  logic              sys_rst_n,
   input  logic [DATA_W-1:0] s_pix_data,
   input  logic              s_pix_sof,
   input  logic              s_pix_valid,
   output logic              s_pix_ready,
   input  logic              data_req,
   input  logic              video_vs,
`ifdef VIDEO_TEST_PATTERN_EN
   input  logic              pattern_sel,
`endif
   output logic [DATA_W-1:0] pixel_data,
   output logic              underflow,
   output logic              sync_err,
   output logic [AW:0]       fifo_level
);

   localparam logic [10:0] X_LAST = 11'(H_DISP - 1);
   localparam logic [10:0] Y_LAST = 11'(V_DISP - 1);

   feeder_state_e     state_r;
   feeder_state_e     state_nx_s;
   logic              vs_r;
   logic              vs_fall_s;
   logic [10:0]       cnt_x_r;
   logic [10:0]       cnt_y_r;
   logic              underflow_r;
   logic              sync_err_r;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              head_sof_s;
   logic [DATA_W-1:0] fifo_rd_data_s;
   logic [AW:0]       fifo_level_s;
   logic              wr_en_s;
   logic              pop_s;
   logic              capture_s;
   logic              slot_s;
   logic              early_sof_s;
   logic              starve_s;
   logic              pos_zero_s;
   logic              last_px_s;
   logic              pattern_on_s;

   assign s_pix_ready = ~fifo_full_s;
   assign wr_en_s     = s_pix_valid & ~fifo_full_s;
   assign vs_fall_s   = vs_r & ~video_vs;
   assign pos_zero_s  = (cnt_x_r == 11'd0) && (cnt_y_r == 11'd0);
   assign last_px_s   = (cnt_x_r == X_LAST) && (cnt_y_r == Y_LAST);

`ifdef VIDEO_TEST_PATTERN_EN
   assign pattern_on_s = pattern_sel;
`else
   assign pattern_on_s = 1'b0;
`endif

   pixel_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AW         (AW)
   ) u_fifo (
      .pixel_clk  (pixel_clk),
      .sys_rst_n  (sys_rst_n),
      .wr_en      (wr_en_s),
      .wr_data    (s_pix_data),
      .wr_sof     (s_pix_sof),
      .rd_en      (pop_s),
      .rd_capture (capture_s),
      .rd_data    (fifo_rd_data_s),
      .head_sof   (head_sof_s),
      .full       (fifo_full_s),
      .empty      (fifo_empty_s),
      .level      (fifo_level_s)
   );

   // Frame sync edge detector; starts low so reset itself never looks like a falling edge.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) vs_r <= 1'b0;
      else            vs_r <= video_vs;
   end

   // FSM state register.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_r <= ST_WAIT_VS;
      else            state_r <= state_nx_s;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_WAIT_VS: begin
            if (vs_fall_s) state_nx_s = ST_ALIGN;
            else           state_nx_s = ST_WAIT_VS;
         end
         ST_ALIGN: begin
            if (!fifo_empty_s && head_sof_s) state_nx_s = ST_ALIGN == state_r ? ST_STREAM : ST_ALIGN;
            else                             state_nx_s = ST_ALIGN;
         end
         ST_STREAM: begin
            if (vs_fall_s)                  state_nx_s = ST_ALIGN;
            else if (slot_s && last_px_s)   state_nx_s = ST_WAIT_VS;
            else                            state_nx_s = ST_STREAM;
         end
         default: state_nx_s = ST_WAIT_VS;
      endcase
   end

   // FSM outputs: pop/capture control and per-slot classification.
   always_comb begin
      pop_s       = 1'b0;
      capture_s   = 1'b0;
      slot_s      = 1'b0;
      early_sof_s = 1'b0;
      starve_s    = 1'b0;
      case (state_r)
         ST_WAIT_VS: pop_s = 1'b0;
         ST_ALIGN: begin
            if (!fifo_empty_s && !head_sof_s) pop_s = 1'b1;
            else                              pop_s = 1'b0;
         end
         ST_STREAM: begin
            // A frame sync in the same cycle wins: the slot is abandoned and the frame restarts.
            if (data_req && !vs_fall_s) begin
               slot_s = 1'b1;
               if (fifo_empty_s) begin
                  starve_s = 1'b1;
               end else if (head_sof_s && !pos_zero_s) begin
                  early_sof_s = 1'b1;
               end else begin
                  pop_s     = 1'b1;
                  capture_s = ~pattern_on_s;
               end
            end else begin
               slot_s = 1'b0;
            end
         end
         default: pop_s = 1'b0;
      endcase
   end

   // Raster position within the active area.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_x_r <= 11'd0;
         cnt_y_r <= 11'd0;
      end else if ((state_r == ST_STREAM) && vs_fall_s) begin
         cnt_x_r <= 11'd0;
         cnt_y_r <= 11'd0;
      end else if (slot_s) begin
         if (last_px_s) begin
            cnt_x_r <= 11'd0;
            cnt_y_r <= 11'd0;
         end else if (cnt_x_r == X_LAST) begin
            cnt_x_r <= 11'd0;
            cnt_y_r <= cnt_y_r + 11'd1;
         end else begin
            cnt_x_r <= cnt_x_r + 11'd1;
         end
      end
   end

   // Sticky per-frame status; a truncated frame reports sync_err into the next one.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         underflow_r <= 1'b0;
         sync_err_r  <= 1'b0;
      end else if (vs_fall_s) begin
         underflow_r <= 1'b0;
         sync_err_r  <= (state_r == ST_STREAM);
      end else begin
         if (starve_s && !pattern_on_s) underflow_r <= 1'b1;
         if (early_sof_s)               sync_err_r  <= 1'b1;
      end
   end

`ifdef VIDEO_TEST_PATTERN_EN
   logic [DATA_W-1:0] pat_pix_r;
   logic [2:0]        bar_idx_s;

   assign bar_idx_s = 3'((32'(cnt_x_r) * 32'd8) / 32'(H_DISP));

   // Colour-bar register; zero whenever the pattern is not driving the slot.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                  pat_pix_r <= {DATA_W{1'b0}};
      else if (slot_s && pattern_on_s) pat_pix_r <= DATA_W'(colour_bar(bar_idx_s));
      else                             pat_pix_r <= {DATA_W{1'b0}};
   end

   assign pixel_data = fifo_rd_data_s | pat_pix_r;
`else
   assign pixel_data = fifo_rd_data_s;
`endif

   assign underflow  = underflow_r;
   assign sync_err   = sync_err_r;
   assign fifo_level = fifo_level_s;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Self-checking bench for video_pixel_feeder with an 8x2 raster and a 16-entry FIFO.
module tb_video_pixel_feeder;

   localparam int H = 8;
   localparam int V = 2;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam int SLOTS = H * V;

   logic        pixel_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [15:0] s_pix_data = 16'h0000;
   logic        s_pix_sof = 1'b0;
   logic        s_pix_valid = 1'b0;
   logic        s_pix_ready;
   logic        data_req = 1'b0;
   logic        video_vs = 1'b1;
   logic [15:0] pixel_data;
   logic        underflow;
   logic        sync_err;
   logic [AW:0] fifo_level;

   int checks = 0;
   int errors = 0;
   logic req_d = 1'b0;
   logic [16:0] push_q[$];
   logic [15:0] exp_q[$];

   typedef struct {
      int          junk;
      int          n_a;
      logic [15:0] base_a;
      int          n_b;
      logic [15:0] base_b;
      int          exp_n;
      logic [15:0] exp_base;
      logic        exp_uf;
      logic        exp_se;
      int          exp_level;
   } row_t;

   row_t rows[5];

   video_pixel_feeder #(
      .DATA_W(16), .FIFO_DEPTH(DEPTH), .AW(AW), .H_DISP(H), .V_DISP(V)
   ) dut (
      .pixel_clk   (pixel_clk),
      .sys_rst_n   (sys_rst_n),
      .s_pix_data  (s_pix_data),
      .s_pix_sof   (s_pix_sof),
      .s_pix_valid (s_pix_valid),
      .s_pix_ready (s_pix_ready),
      .data_req    (data_req),
      .video_vs    (video_vs),
`ifdef VIDEO_TEST_PATTERN_EN
      .pattern_sel (1'b0),
`endif
      .pixel_data  (pixel_data),
      .underflow   (underflow),
      .sync_err    (sync_err),
      .fifo_level  (fifo_level)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Upstream driver: present the queue head each cycle, retire it once ready is seen.
   initial begin
      forever begin
         @(negedge pixel_clk);
         if (push_q.size() > 0) begin
            s_pix_valid = 1'b1;
            {s_pix_sof, s_pix_data} = push_q[0];
            #1;
            if (s_pix_ready) push_q.delete(0);
         end else begin
            s_pix_valid = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge pixel_clk);
         req_d = data_req;
      end
   end

   // Scoreboard: every requested slot yields the queued expectation one cycle later, else black.
   initial begin
      forever begin
         @(negedge pixel_clk);
         if (req_d) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underrun actual=%0h required=none", pixel_data);
            end else begin
               check("pixel", 32'(pixel_data), 32'(exp_q.pop_front()));
            end
         end else begin
            check("black_idle", 32'(pixel_data), 32'h0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic enqueue(input int n, input logic [15:0] base, input logic first_sof);
      for (int i = 0; i < n; i++)
         push_q.push_back({(i == 0) ? first_sof : 1'b0, base + 16'(i)});
   endtask

   task automatic pulse_vs();
      @(negedge pixel_clk);
      video_vs = 1'b0;
      repeat (2) @(negedge pixel_clk);
      video_vs = 1'b1;
   endtask

   task automatic wait_loaded();
      int t = 0;
      while (!(push_q.size() == 0 || fifo_level == 5'(DEPTH)) && t < 300) begin
         @(negedge pixel_clk);
         t++;
      end
      check("load_wait", 32'(t < 300), 32'h1);
   endtask

   task automatic send_req(input logic [15:0] exp);
      @(negedge pixel_clk);
      data_req = 1'b1;
      exp_q.push_back(exp);
   endtask

   initial begin
      rows[0] = '{0, 16, 16'h0001, 0, 16'h0000, 16, 16'h0001, 1'b0, 1'b0, 0};
      rows[1] = '{3, 16, 16'h0A00, 0, 16'h0000, 16, 16'h0A00, 1'b0, 1'b0, 0};
      rows[2] = '{0, 5,  16'h0500, 0, 16'h0000, 5,  16'h0500, 1'b1, 1'b0, 0};
      rows[3] = '{0, 10, 16'h0100, 16, 16'h0200, 10, 16'h0100, 1'b0, 1'b1, 16};
      rows[4] = '{0, 0,  16'h0000, 0, 16'h0000, 16, 16'h0200, 1'b0, 1'b0, 0};

      repeat (3) @(negedge pixel_clk);
      check("rst_pixel", 32'(pixel_data), 32'h0);
      check("rst_level", 32'(fifo_level), 32'h0);
      check("rst_ready", 32'(s_pix_ready), 32'h1);
      check("rst_uf", 32'(underflow), 32'h0);
      check("rst_se", 32'(sync_err), 32'h0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge pixel_clk);

      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < rows[r].junk; j++) push_q.push_back({1'b0, 16'hEE00 + 16'(j)});
         enqueue(rows[r].n_a, rows[r].base_a, 1'b1);
         enqueue(rows[r].n_b, rows[r].base_b, 1'b1);
         pulse_vs();
         check("vs_clears_uf", 32'(underflow), 32'h0);
         check("vs_clears_se", 32'(sync_err), 32'h0);
         wait_loaded();
         repeat (4) @(negedge pixel_clk);
         for (int k = 0; k < SLOTS; k++)
            send_req((k < rows[r].exp_n) ? rows[r].exp_base + 16'(k) : 16'h0000);
         @(negedge pixel_clk);
         data_req = 1'b0;
         repeat (3) @(negedge pixel_clk);
         check("frame_uf", 32'(underflow), 32'(rows[r].exp_uf));
         check("frame_se", 32'(sync_err), 32'(rows[r].exp_se));
         check("frame_level", 32'(fifo_level), 32'(rows[r].exp_level));
      end

      // Full FIFO: 20 words offered with no requests, then pop/push interplay at the boundary.
      enqueue(20, 16'h0C00, 1'b1);
      wait_loaded();
      repeat (2) @(negedge pixel_clk);
      check("full_level", 32'(fifo_level), 32'(DEPTH));
      check("full_ready", 32'(s_pix_ready), 32'h0);
      check("full_held", 32'(push_q.size()), 32'h4);
      pulse_vs();
      repeat (2) @(negedge pixel_clk);
      check("full_level_stream", 32'(fifo_level), 32'(DEPTH));
      @(negedge pixel_clk);
      data_req = 1'b1;
      exp_q.push_back(16'h0C00);
      @(negedge pixel_clk);
      check("lvl_pop_full", 32'(fifo_level), 32'(DEPTH - 1));
      exp_q.push_back(16'h0C01);
      @(negedge pixel_clk);
      check("lvl_push_pop", 32'(fifo_level), 32'(DEPTH - 1));
      data_req = 1'b0;
      @(negedge pixel_clk);
      check("lvl_refill", 32'(fifo_level), 32'(DEPTH));
      for (int k = 2; k < SLOTS; k++) send_req(16'h0C00 + 16'(k));
      @(negedge pixel_clk);
      data_req = 1'b0;
      repeat (4) @(negedge pixel_clk);
      check("full_left", 32'(fifo_level), 32'h4);
      check("full_flags", 32'({underflow, sync_err}), 32'h0);

      // Reset with data still buffered discards it.
      @(negedge pixel_clk);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_level", 32'(fifo_level), 32'h0);
      check("mid_rst_ready", 32'(s_pix_ready), 32'h1);
      check("mid_rst_pixel", 32'(pixel_data), 32'h0);
      repeat (2) @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      @(negedge pixel_clk);
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
